// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx -- I2S serial audio receiver with a first-word-fall-through FIFO.
//
// The external bit clock, word select and data are synchronized into the
// wb_clk_i domain. Bits are taken on each bclk rising edge, so wb_clk_i must
// run at least 4x faster than bclk. Words are assembled MSB-first and pushed
// into the sample FIFO together with the channel they belong to.
//
// Ports
//   wb_clk_i, wb_rst_i   system clock, asynchronous active-high reset
//   enable               receiver enable; low discards any partial word
//   i2s_bclk/lrclk/din   asynchronous I2S inputs (lrclk: 0 = left, 1 = right)
//   rx_data, rx_chan     FIFO head sample and its channel (0 when empty)
//   rx_valid, rx_ready   FIFO output handshake
//   fifo_level           current FIFO occupancy
//   overflow, ovf_clr    sticky dropped-word flag and its clear
//   o_dbg_state          receiver FSM state (0 DISABLED, 1 SYNC, 2 RUN)
//
// Handshake: a sample is transferred on every wb_clk_i rising edge where
// rx_valid and rx_ready are both high. rx_valid does not depend on
// rx_ready, and rx_data/rx_chan are stable while rx_valid is high and no
// transfer has taken place.
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     enable,
    input  logic                     i2s_bclk,
    input  logic                     i2s_lrclk,
    input  logic                     i2s_din,
    output logic [DATA_W-1:0]        rx_data,
    output logic                     rx_chan,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [1:0]               o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    // ---------------- input synchronizers ----------------
    logic r_bclk_s1, r_bclk_s2, r_bclk_d;
    logic r_lr_s1, r_lr_s2;
    logic r_din_s1, r_din_s2;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_d  <= 1'b0;
            r_lr_s1   <= 1'b0;
            r_lr_s2   <= 1'b0;
            r_din_s1  <= 1'b0;
            r_din_s2  <= 1'b0;
        end else begin
            r_bclk_s1 <= i2s_bclk;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_d  <= r_bclk_s2;
            r_lr_s1   <= i2s_lrclk;
            r_lr_s2   <= r_lr_s1;
            r_din_s1  <= i2s_din;
            r_din_s2  <= r_din_s1;
        end
    end

    logic w_strobe;
    assign w_strobe = r_bclk_s2 & ~r_bclk_d;

    // ---------------- word assembly FSM ----------------
    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_cnt;
    logic              r_lr_d;
    // lr_d only means something once a strobe has loaded it; until then a
    // mismatch against its reset value is not a real channel boundary.
    logic              r_lr_seen;
    logic              r_push;
    logic [DATA_W-1:0] r_push_data;
    logic              r_push_chan;

    logic              w_lr_chg;
    logic              w_room;
    logic [DATA_W-1:0] w_shift_in;
    logic [DATA_W-1:0] w_final_word;
    logic [CW-1:0]     w_final_cnt;
    logic [CW-1:0]     w_pad;
    logic [DATA_W-1:0] w_aligned;

    assign w_lr_chg     = r_lr_s2 != r_lr_d;
    assign w_room       = r_cnt < FULL_CNT;
    assign w_shift_in   = {r_shift[DATA_W-2:0], r_din_s2};
    // The boundary strobe still carries the last bit of the word (one-bit
    // delay), unless the word is already full.
    assign w_final_word = w_room ? w_shift_in : r_shift;
    assign w_final_cnt  = w_room ? r_cnt + 1'b1 : r_cnt;
    // Short words are left-aligned with zero LSBs.
    assign w_pad        = FULL_CNT - w_final_cnt;
    assign w_aligned    = w_final_word << w_pad;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_DISABLED;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_lr_d      <= 1'b0;
            r_lr_seen   <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_push_chan <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_strobe) begin
                r_lr_d    <= r_lr_s2;
                r_lr_seen <= 1'b1;
            end
            if (!enable) begin
                r_state <= ST_DISABLED;
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_DISABLED: r_state <= ST_SYNC;
                    ST_SYNC: begin
                        // The boundary bit itself belongs to the word we
                        // missed, so it is dropped.
                        if (w_strobe && r_lr_seen && w_lr_chg) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_strobe) begin
                            if (w_lr_chg) begin
                                r_push      <= 1'b1;
                                r_push_data <= w_aligned;
                                r_push_chan <= r_lr_d;
                                r_shift     <= '0;
                                r_cnt       <= '0;
                            end else if (w_room) begin
                                r_shift <= w_shift_in;
                                r_cnt   <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_DISABLED;
                endcase
            end
        end
    end

    assign o_dbg_state = r_state;

    // ---------------- sample FIFO (first-word fall-through) ----------------
    logic [DATA_W:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_level;
    logic            r_ovf;

    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic            w_drop;
    logic [DATA_W:0] w_head;

    assign w_full = r_level == FULL_LVL;
    assign w_pop  = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_wr   = r_push & (~w_full | w_pop);
    assign w_drop = r_push & w_full & ~w_pop;
    assign w_head = r_mem[r_rptr];

    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= {r_push_chan, r_push_data};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // A new drop wins over a clear in the same cycle.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Head is masked while empty so stale memory never shows on the outputs.
    assign rx_valid   = r_level != '0;
    assign rx_data    = rx_valid ? w_head[DATA_W-1:0] : '0;
    assign rx_chan    = rx_valid ? w_head[DATA_W] : 1'b0;
    assign fifo_level = r_level;
    assign overflow   = r_ovf;

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, giving the width of the received audio word (range 8..32).
REQ-002 The module SHALL have parameter DEPTH, default 8, giving the number of sample FIFO entries (power of two, at least 2).
REQ-003 The module SHALL have port wb_clk_i, input, 1 bit, the single system clock; every flop is clocked on its rising edge.
REQ-004 The module SHALL have port wb_rst_i, input, 1 bit, the reset, which is asynchronous and active-high.
REQ-005 The module SHALL have port enable, input, 1 bit, the receiver enable.
REQ-006 The module SHALL have port i2s_bclk, input, 1 bit, the external bit clock, asynchronous to wb_clk_i.
REQ-007 The module SHALL have port i2s_lrclk, input, 1 bit, the external word select (0 = left, 1 = right), asynchronous.
REQ-008 The module SHALL have port i2s_din, input, 1 bit, the serial audio data, asynchronous.
REQ-009 The module SHALL have port rx_data, output, DATA_W bits, the FIFO head sample.
REQ-010 The module SHALL have port rx_chan, output, 1 bit, the channel of the FIFO head sample.
REQ-011 The module SHALL have port rx_valid, output, 1 bit, asserted when the FIFO is non-empty.
REQ-012 The module SHALL have port rx_ready, input, 1 bit, the consumer accept signal.
REQ-013 The module SHALL have port fifo_level, output, clog2(DEPTH)+1 bits, the current FIFO occupancy.
REQ-014 The module SHALL have port overflow, output, 1 bit, a sticky flag set when a word is dropped.
REQ-015 The module SHALL have port ovf_clr, input, 1 bit, which clears overflow.

Function
REQ-016 The module SHALL pass i2s_bclk, i2s_lrclk and i2s_din through 2-flop synchronizers.
REQ-017 The module SHALL register the synchronized bclk once more and detect a rising edge as sync high and previous low, giving a one-cycle bit strobe.
REQ-018 The module SHALL support bclk up to wb_clk_i/4; behaviour at higher bclk rates is undefined.
REQ-019 The module SHALL sample lr and din on each bit strobe and keep lr_d, the lr value from the previous strobe.
REQ-020 The FSM SHALL have the states DISABLED, SYNC and RUN.
REQ-021 The FSM SHALL go to DISABLED whenever enable is low, clearing the shift register and bit count in the same cycle.
REQ-022 The FSM SHALL move from DISABLED to SYNC on the first cycle enable is high.
REQ-023 In SYNC, the FSM SHALL move to RUN on the first strobe with lr != lr_d, and that strobe's bit SHALL be discarded.
REQ-024 In RUN, a strobe with lr == lr_d SHALL shift din into the word MSB-first, incrementing the bit count saturating at DATA_W; bits beyond DATA_W SHALL be ignored.
REQ-025 In RUN, a strobe with lr != lr_d SHALL shift its din as the final bit of the current word when count < DATA_W (I2S one-bit delay).
REQ-026 On that lr-change strobe, the current word SHALL be pushed with rx_chan = lr_d, and the count and shift register SHALL then clear.
REQ-027 A word with fewer than DATA_W received bits SHALL be pushed left-aligned, with its LSBs zero-filled.
REQ-028 Each push SHALL reach the FIFO no later than 5 wb_clk_i cycles after the bclk rising edge at the pin.
REQ-029 The FIFO SHALL be first-word fall-through, so rx_data and rx_chan are valid whenever rx_valid is high.
REQ-030 A pop SHALL occur on a cycle where rx_valid and rx_ready are both high.
REQ-031 A push into a full FIFO SHALL be dropped and SHALL set overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-032 Simultaneous push and pop SHALL leave fifo_level unchanged, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-033 ovf_clr SHALL clear overflow on the next cycle; when ovf_clr and a new drop occur in the same cycle, overflow SHALL remain set.
REQ-034 Deasserting enable SHALL discard any partial word but SHALL retain FIFO contents, which remain readable.

Reset
REQ-035 While wb_rst_i is high, the FSM SHALL be in DISABLED, and the synchronizers, shift register, count and FIFO pointers SHALL be 0.
REQ-036 While wb_rst_i is high, rx_valid, rx_data, rx_chan, overflow and fifo_level SHALL all be 0.
REQ-037 Reset asserted mid-word or mid-transfer SHALL discard all data, and after release the block SHALL resync via SYNC.

Verification
REQ-038 Stimulus: DATA_W=16, wb_clk_i = 8x bclk, enable, stereo frames L=0xA5C3, R=0x1234, 16 bits per channel. Required response: the first partial word is discarded; the FIFO then yields (0,0xA5C3) and (1,0x1234) in order.
REQ-039 Stimulus: 24-bit slots with L=0xABCDEF. Required response: the pushed word is 0xABCD.
REQ-040 Stimulus: 12-bit slots with L=0xFFF. Required response: the pushed word is 0xFFF0.
REQ-041 Stimulus: rx_ready held low for 10 words with DEPTH=8. Required response: fifo_level reaches 8, overflow is set, and the first 8 words are retained.
REQ-042 Stimulus: ovf_clr pulsed after the overflow case. Required response: overflow is 0.
REQ-043 Stimulus: push and pop in the same cycle while full. Required response: fifo_level stays 8 and overflow does not set.
REQ-044 Stimulus: wb_rst_i pulsed mid-word. Required response: all outputs are 0 immediately, and the next complete word after resync is correct.
REQ-045 Stimulus: enable dropped mid-word. Required response: no push occurs, and existing entries remain poppable.
